// File: rtl/sb_pkg.sv
// Shared constants, FSM state types and the CRC helper for the sideband receive path.
package sb_pkg;

  localparam logic [7:0] DLE     = 8'hFE;
  localparam logic [7:0] STX_CMD = 8'h05;
  localparam logic [7:0] STX_RSP = 8'h04;
  localparam logic [7:0] ETX     = 8'h40;

  localparam logic [15:0] CRC_POLY = 16'h8005;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;

  typedef enum logic [1:0] {
    B_IDLE,
    B_DATA,
    B_STOP
  } byte_state_t;

  typedef enum logic [2:0] {
    F_IDLE,
    F_SOF,
    F_PAY,
    F_ESC,
    F_DROP,
    F_DROP_ESC
  } frame_state_t;

  // LSB-first CRC-16 step: the polynomial is applied bit-reversed.
  function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] data);
    logic [15:0] poly_rev;
    logic [15:0] c;
    for (int i = 0; i < 16; i++) poly_rev[i] = CRC_POLY[15-i];
    c = crc ^ {8'h00, data};
    for (int i = 0; i < 8; i++) c = c[0] ? ((c >> 1) ^ poly_rev) : (c >> 1);
    return c;
  endfunction

endpackage

// File: rtl/sb_uart_rx.sv
// Sideband byte deserializer: start bit, 8 data bits LSB first, stop bit.
module sb_uart_rx
  import sb_pkg::*;
(
  input  logic       sb_clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       sbrx,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       err_framing
);

  byte_state_t state;
  logic [2:0]  cnt;
  logic [7:0]  shift;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the values from before the clock edge.
  always_ff @(posedge sb_clk) begin
    if (rst || !enable) begin
      state       <= B_IDLE;
      cnt         <= 3'd0;
      shift       <= 8'h00;
      byte_data   <= 8'h00;
      byte_valid  <= 1'b0;
      err_framing <= 1'b0;
    end else begin
      byte_valid  <= 1'b0;
      err_framing <= 1'b0;
      case (state)
        B_IDLE: begin
          if (!sbrx) begin
            state <= B_DATA;
            cnt   <= 3'd0;
          end
        end
        B_DATA: begin
          shift[cnt] <= sbrx;
          cnt        <= cnt + 3'd1;
          if (cnt == 3'd7) state <= B_STOP;
        end
        B_STOP: begin
          if (sbrx) begin
            byte_valid <= 1'b1;
            byte_data  <= shift;
          end else begin
            err_framing <= 1'b1;
          end
          state <= B_IDLE;
        end
        default: state <= B_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/sb_rx_transaction_parser.sv
// Sideband transaction parser: strips DLE/STX..DLE/ETX framing and DLE stuffing.
// Optional CRC-16 payload check when SB_RX_CRC_CHECK_EN is defined (adds err_crc).
module sb_rx_transaction_parser
  import sb_pkg::*;
#(
  parameter int MAX_BYTES = 16,
  parameter int LEN_W     = $clog2(MAX_BYTES + 1)
) (
  input  logic                   sb_clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic                   sbrx,
  output logic                   trans_valid,
  output logic                   trans_is_rsp,
  output logic [LEN_W-1:0]       trans_len,
  output logic [8*MAX_BYTES-1:0] trans_data,
  output logic                   err_framing,
  output logic                   err_overflow,
  output logic                   err_proto
`ifdef SB_RX_CRC_CHECK_EN
  ,
  output logic                   err_crc
`endif
);

  logic [7:0] byte_data;
  logic       byte_valid;

  sb_uart_rx u_uart_rx (
    .sb_clk      (sb_clk),
    .rst         (rst),
    .enable      (enable),
    .sbrx        (sbrx),
    .byte_data   (byte_data),
    .byte_valid  (byte_valid),
    .err_framing (err_framing)
  );

  frame_state_t           fstate;
  logic [LEN_W-1:0]       len;
  logic [8*MAX_BYTES-1:0] pay;
  logic                   is_rsp;
  logic                   store_req;
  logic                   full;
`ifdef SB_RX_CRC_CHECK_EN
  logic [15:0]            crc;
`endif

  // NOTE: every combinational output is assigned on every path, so no latch
  // is inferred.
  always_comb begin
    store_req = 1'b0;
    if (byte_valid) begin
      if (fstate == F_PAY && byte_data != DLE) store_req = 1'b1;
      if (fstate == F_ESC && byte_data == DLE) store_req = 1'b1;
    end
  end

  assign full = (len == LEN_W'(MAX_BYTES));

  // NOTE: the payload buffer is a small register bank, so it is cleared on
  // reset like any other flop; a RAM-backed buffer would not be.
  always_ff @(posedge sb_clk) begin
    if (rst) begin
      fstate       <= F_IDLE;
      len          <= '0;
      pay          <= '0;
      is_rsp       <= 1'b0;
      trans_valid  <= 1'b0;
      trans_is_rsp <= 1'b0;
      trans_len    <= '0;
      trans_data   <= '0;
      err_overflow <= 1'b0;
      err_proto    <= 1'b0;
`ifdef SB_RX_CRC_CHECK_EN
      crc          <= CRC_INIT;
      err_crc      <= 1'b0;
`endif
    end else if (!enable) begin
      // Drop any partial transaction but keep the last committed one visible.
      fstate       <= F_IDLE;
      len          <= '0;
      trans_valid  <= 1'b0;
      err_overflow <= 1'b0;
      err_proto    <= 1'b0;
`ifdef SB_RX_CRC_CHECK_EN
      err_crc      <= 1'b0;
`endif
    end else begin
      trans_valid  <= 1'b0;
      err_overflow <= 1'b0;
      err_proto    <= 1'b0;
`ifdef SB_RX_CRC_CHECK_EN
      err_crc      <= 1'b0;
`endif
      if (err_framing) begin
        fstate <= F_IDLE;
      end else if (byte_valid) begin
        case (fstate)
          F_IDLE: if (byte_data == DLE) fstate <= F_SOF;
          F_SOF: begin
            if (byte_data == STX_CMD || byte_data == STX_RSP) begin
              is_rsp <= (byte_data == STX_RSP);
              len    <= '0;
              pay    <= '0;
              fstate <= F_PAY;
`ifdef SB_RX_CRC_CHECK_EN
              crc    <= CRC_INIT;
`endif
            end else begin
              err_proto <= 1'b1;
              fstate    <= F_IDLE;
            end
          end
          F_PAY: if (byte_data == DLE) fstate <= F_ESC;
          F_ESC: begin
            if (byte_data == ETX) begin
              fstate <= F_IDLE;
`ifdef SB_RX_CRC_CHECK_EN
              // A message followed by its own CRC (low byte first) leaves a zero residue.
              if (len < LEN_W'(2) || crc != 16'h0000) begin
                err_crc <= 1'b1;
              end else begin
                trans_valid  <= 1'b1;
                trans_is_rsp <= is_rsp;
                trans_len    <= len - LEN_W'(2);
                for (int i = 0; i < MAX_BYTES; i++)
                  trans_data[8*i +: 8] <= (i + 2 < int'(len)) ? pay[8*i +: 8] : 8'h00;
              end
`else
              trans_valid  <= 1'b1;
              trans_is_rsp <= is_rsp;
              trans_len    <= len;
              trans_data   <= pay;
`endif
            end else if (byte_data != DLE) begin
              err_proto <= 1'b1;
              fstate    <= F_IDLE;
            end
          end
          F_DROP:     if (byte_data == DLE) fstate <= F_DROP_ESC;
          F_DROP_ESC: fstate <= (byte_data == ETX) ? F_IDLE : F_DROP;
          default:    fstate <= F_IDLE;
        endcase

        if (store_req) begin
          if (full) begin
            err_overflow <= 1'b1;
            fstate       <= F_DROP;
          end else begin
            for (int i = 0; i < MAX_BYTES; i++)
              if (i == int'(len)) pay[8*i +: 8] <= byte_data;
            len    <= len + LEN_W'(1);
            fstate <= F_PAY;
`ifdef SB_RX_CRC_CHECK_EN
            crc    <= crc16_byte(crc, byte_data);
`endif
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_sb_rx_transaction_parser.sv
// Directed bench for sb_rx_transaction_parser with a byte-level reference model.
module tb_sb_rx_transaction_parser;
  import sb_pkg::*;

  localparam int MAX = 16;
  localparam int LW  = $clog2(MAX + 1);

  logic            sb_clk = 1'b0;
  logic            rst    = 1'b1;
  logic            enable = 1'b1;
  logic            sbrx   = 1'b1;
  logic            trans_valid, trans_is_rsp, err_framing, err_overflow, err_proto;
  logic [LW-1:0]   trans_len;
  logic [8*MAX-1:0] trans_data;

  sb_rx_transaction_parser #(.MAX_BYTES(MAX)) dut (
    .sb_clk       (sb_clk),
    .rst          (rst),
    .enable       (enable),
    .sbrx         (sbrx),
    .trans_valid  (trans_valid),
    .trans_is_rsp (trans_is_rsp),
    .trans_len    (trans_len),
    .trans_data   (trans_data),
    .err_framing  (err_framing),
    .err_overflow (err_overflow),
    .err_proto    (err_proto)
  );

  always #5 sb_clk = ~sb_clk;

  int checks    = 0;
  int failures  = 0;
  int cyc       = 0;
  int last_stop = 0;
  int seen_fe   = 0;
  int seen_ov   = 0;
  int seen_pe   = 0;
  bit cmp_on    = 1'b0;

  always @(posedge sb_clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  // Reference model: expected pulses keyed by cycle, held-output updates queued.
  typedef struct {
    int              cyc;
    logic            rsp;
    logic [LW-1:0]   len;
    logic [8*MAX-1:0] data;
  } held_t;

  held_t           hq[$];
  bit              ev_tv[int];
  bit              ev_fe[int];
  bit              ev_ov[int];
  bit              ev_pe[int];
  logic            exp_rsp  = 1'b0;
  logic [LW-1:0]   exp_len  = '0;
  logic [8*MAX-1:0] exp_data = '0;

  bit         m_in_frame, m_esc, m_drop, m_hunt, m_rsp;
  logic [7:0] m_q[$];

  task automatic model_clear();
    m_in_frame = 0; m_esc = 0; m_drop = 0; m_hunt = 0;
    m_q.delete();
  endtask

  task automatic push_held(input int c, input logic rsp, input logic [7:0] q[$]);
    held_t h;
    h.cyc  = c;
    h.rsp  = rsp;
    h.len  = LW'(q.size());
    h.data = '0;
    foreach (q[i]) h.data[8*i +: 8] = q[i];
    hq.push_back(h);
  endtask

  task automatic model_add(input logic [7:0] b, input int c);
    if (m_q.size() == MAX) begin
      ev_ov[c+2] = 1;
      m_in_frame = 0;
      m_drop     = 1;
    end else begin
      m_q.push_back(b);
    end
  endtask

  task automatic model_byte(input logic [7:0] b, input bit stop_ok, input int c);
    if (!stop_ok) begin
      ev_fe[c+1] = 1;
      model_clear();
    end else if (m_drop) begin
      if (m_esc) begin
        m_esc = 0;
        if (b == ETX) m_drop = 0;
      end else if (b == DLE) m_esc = 1;
    end else if (!m_in_frame) begin
      if (m_hunt) begin
        m_hunt = 0;
        if (b == STX_CMD || b == STX_RSP) begin
          m_in_frame = 1;
          m_rsp      = (b == STX_RSP);
          m_q.delete();
        end else ev_pe[c+2] = 1;
      end else if (b == DLE) m_hunt = 1;
    end else if (m_esc) begin
      m_esc = 0;
      if (b == ETX) begin
        m_in_frame = 0;
        ev_tv[c+2] = 1;
        push_held(c + 2, m_rsp, m_q);
      end else if (b == DLE) model_add(b, c);
      else begin
        ev_pe[c+2] = 1;
        m_in_frame = 0;
      end
    end else if (b == DLE) m_esc = 1;
    else model_add(b, c);
  endtask

  always @(negedge sb_clk) begin
    if (cmp_on) begin
      while (hq.size() > 0 && hq[0].cyc <= cyc) begin
        exp_rsp  = hq[0].rsp;
        exp_len  = hq[0].len;
        exp_data = hq[0].data;
        hq.delete(0);
      end
      if (err_framing === 1'b1)  seen_fe++;
      if (err_overflow === 1'b1) seen_ov++;
      if (err_proto === 1'b1)    seen_pe++;
      check("pulses", {trans_valid, err_framing, err_overflow, err_proto},
            {ev_tv.exists(cyc) != 0, ev_fe.exists(cyc) != 0,
             ev_ov.exists(cyc) != 0, ev_pe.exists(cyc) != 0});
      check("held", {trans_is_rsp, trans_len, trans_data}, {exp_rsp, exp_len, exp_data});
    end
  end

  task automatic send_bit(input logic b);
    @(negedge sb_clk);
    sbrx = b;
  endtask

  task automatic idle(input int n);
    repeat (n) send_bit(1'b1);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stop_ok);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(stop_ok);
    last_stop = cyc;
    model_byte(b, stop_ok, cyc);
    if (!stop_ok) send_bit(1'b1);
  endtask

  task automatic send_seq(input logic [7:0] s[$]);
    foreach (s[i]) send_byte(s[i], 1'b1);
  endtask

  task automatic wait_valid(input string name);
    int lat;
    lat = -1;
    for (int k = 0; k < 20; k++) begin
      @(negedge sb_clk);
      if (trans_valid === 1'b1) begin
        lat = cyc - last_stop;
        break;
      end
    end
    check(name, lat, 2);
  endtask

  task automatic pulse_reset();
    logic [7:0] empty[$];
    @(negedge sb_clk);
    rst = 1'b1;
    model_clear();
    push_held(cyc + 1, 1'b0, empty);
    @(negedge sb_clk);
    rst = 1'b0;
  endtask

  task automatic enable_low();
    @(negedge sb_clk);
    enable = 1'b0;
    model_clear();
    repeat (2) @(negedge sb_clk);
    enable = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] seq[$];
    model_clear();
    repeat (3) @(negedge sb_clk);
    rst    = 1'b0;
    cmp_on = 1'b1;
    check("rst_valid", {trans_valid, err_framing, err_overflow, err_proto}, 4'b0000);
    check("rst_len", trans_len, 0);
    check("rst_data", trans_data, 0);
    idle(3);

    // Command with two payload bytes; junk byte before the frame is ignored.
    send_byte(8'h55, 1'b1);
    seq = '{8'hFE, 8'h05, 8'h12, 8'h34, 8'hFE, 8'h40};
    send_seq(seq);
    wait_valid("cmd_latency");
    check("cmd_rsp", trans_is_rsp, 0);
    check("cmd_len", trans_len, 2);
    check("cmd_b0", trans_data[7:0], 8'h12);
    check("cmd_b1", trans_data[15:8], 8'h34);
    idle(2);

    // Response carrying stuffed DLE bytes.
    seq = '{8'hFE, 8'h04, 8'hFE, 8'hFE, 8'hFE, 8'hFE, 8'hAA, 8'hFE, 8'h40};
    send_seq(seq);
    wait_valid("rsp_latency");
    check("rsp_rsp", trans_is_rsp, 1);
    check("rsp_len", trans_len, 3);
    check("rsp_data", trans_data, 128'hAA_FE_FE);
    idle(2);

    // Bad stop bit on the second payload byte, then a clean frame.
    send_byte(8'hFE, 1'b1);
    send_byte(8'h05, 1'b1);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b0);
    idle(4);
    check("fe_seen", seen_fe, 1);
    check("fe_hold_len", trans_len, 3);
    seq = '{8'hFE, 8'h05, 8'h77, 8'hFE, 8'h40};
    send_seq(seq);
    wait_valid("fe_next_latency");
    check("fe_next_len", trans_len, 1);
    check("fe_next_data", trans_data, 128'h77);
    idle(2);

    // 17 payload bytes overflow the buffer; held outputs must survive.
    seq = '{8'hFE, 8'h04};
    for (int i = 0; i < 17; i++) seq.push_back(8'(i));
    seq.push_back(8'hFE);
    seq.push_back(8'h40);
    send_seq(seq);
    idle(4);
    check("ovf_seen", seen_ov, 1);
    check("ovf_hold_len", trans_len, 1);
    check("ovf_hold_data", trans_data, 128'h77);
    check("ovf_hold_rsp", trans_is_rsp, 0);

    // Illegal byte after DLE, then a zero-length response.
    seq = '{8'hFE, 8'h05, 8'hFE, 8'h33};
    send_seq(seq);
    idle(4);
    check("proto_seen", seen_pe, 1);
    seq = '{8'hFE, 8'h04, 8'hFE, 8'h40};
    send_seq(seq);
    wait_valid("zero_latency");
    check("zero_len", trans_len, 0);
    check("zero_rsp", trans_is_rsp, 1);
    check("zero_data", trans_data, 0);
    idle(2);

    // Missing STX after DLE.
    seq = '{8'hFE, 8'h99};
    send_seq(seq);
    idle(4);
    check("nostx_seen", seen_pe, 2);

    // Reset mid-payload, then a full frame.
    seq = '{8'hFE, 8'h05, 8'hAB};
    send_seq(seq);
    idle(2);
    pulse_reset();
    idle(2);
    check("mid_rst_len", trans_len, 0);
    seq = '{8'hFE, 8'h05, 8'hCD, 8'hEF, 8'hFE, 8'h40};
    send_seq(seq);
    wait_valid("post_rst_latency");
    check("post_rst_len", trans_len, 2);
    check("post_rst_data", trans_data, 128'hEF_CD);
    idle(2);

    // Enable dropped mid-payload.
    seq = '{8'hFE, 8'h04, 8'h01};
    send_seq(seq);
    idle(2);
    enable_low();
    check("en_hold_len", trans_len, 2);
    seq = '{8'hFE, 8'h04, 8'h02, 8'hFE, 8'h40};
    send_seq(seq);
    wait_valid("post_en_latency");
    check("post_en_len", trans_len, 1);
    check("post_en_data", trans_data, 128'h02);
    idle(2);

    // Exactly MAX_BYTES payload bytes, last one a stuffed DLE.
    seq = '{8'hFE, 8'h05};
    for (int i = 0; i < 15; i++) seq.push_back(8'(8'h10 + i));
    seq.push_back(8'hFE);
    seq.push_back(8'hFE);
    seq.push_back(8'hFE);
    seq.push_back(8'h40);
    send_seq(seq);
    wait_valid("full_latency");
    check("full_len", trans_len, 16);
    check("full_b0", trans_data[7:0], 8'h10);
    check("full_b14", trans_data[119:112], 8'h1E);
    check("full_b15", trans_data[127:120], 8'hFE);
    check("full_no_ovf", seen_ov, 1);

    idle(5);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
